// File: rtl/gate_rr_arbiter.sv
// gate_rr_arbiter: round-robin share of one gate (c = a ^ b) among NUM_REQ requesters, one transaction in flight.
// Optional GATE_RR_ARBITER_CHECK_EN adds a sticky err output flagging gate_c != gate_a ^ gate_b.
module gate_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int GATE_LATENCY = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [NUM_REQ-1:0] req_a,
  input  logic [NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0] req_ready,
  output logic [NUM_REQ-1:0] resp_valid,
  output logic               resp_c,
  input  logic [NUM_REQ-1:0] resp_ready,
  output logic               gate_a,
  output logic               gate_b,
  input  logic               gate_c,
  input  logic               gate_ready
`ifdef GATE_RR_ARBITER_CHECK_EN
  ,
  output logic               err
`endif
);
  localparam int IW = $clog2(NUM_REQ);
  localparam logic [IW:0] NR = (IW+1)'(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nxt;
  logic [IW-1:0] rr_ptr, grant, pick;
  logic [IW:0] idx;
  logic [3:0] cnt;
  logic found, accept, sample, done;
  // first valid requester at or above rr_ptr, wrapping explicitly at NUM_REQ-1
  always_comb begin
    pick = rr_ptr;
    found = 1'b0;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, rr_ptr} + (IW+1)'(i);
      idx = (idx >= NR) ? idx - NR : idx;
      if (!found && req_valid[idx[IW-1:0]]) begin
        pick = idx[IW-1:0];
        found = 1'b1;
      end
    end
  end
  assign accept = state == IDLE && !reset && gate_ready && found;
  assign sample = state == EXEC && gate_ready && cnt == 4'(GATE_LATENCY - 1);
  assign done = state == RESP && resp_ready[grant];
  assign req_ready = accept ? ONE << pick : '0;
  assign resp_valid = state == RESP ? ONE << grant : '0;
  // next state: accept -> EXEC, gate sampled -> RESP, response taken -> IDLE
  always_comb begin
    state_nxt = accept ? EXEC : sample ? RESP : done ? IDLE : state;
  end
  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nxt;
  end
  // datapath: operands held between transactions, pointer moves only on response completion
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
      grant <= '0;
      gate_a <= 1'b0;
      gate_b <= 1'b0;
      resp_c <= 1'b0;
      cnt <= '0;
    end else begin
      if (accept) begin
        grant <= pick;
        gate_a <= req_a[pick];
        gate_b <= req_b[pick];
        cnt <= '0;
      end else if (state == EXEC && gate_ready) cnt <= cnt + 4'd1;
      if (sample) resp_c <= gate_c;
      if (done) rr_ptr <= (grant == IW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
    end
  end
`ifdef GATE_RR_ARBITER_CHECK_EN
  // sticky flag when the gate result disagrees with the XOR of the driven operands
  always_ff @(posedge clk) begin
    if (reset) err <= 1'b0;
    else if (sample && gate_c != (gate_a ^ gate_b)) err <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_gate_rr_arbiter.sv
// tb_gate_rr_arbiter: vector table plus corner-case sequences, results checked through a scoreboard queue.
module tb_gate_rr_arbiter;
  logic clk, reset;
  logic [3:0] rv, ra, rb, rq, pv, pr;
  logic pc, ga, gb, gc, grdy, gmode;
  logic [3:0] rv1, ra1, rb1, rq1, pv1, pr1;
  logic pc1, ga1, gb1, gc1, grdy1;
  int total = 0, bad = 0;
  typedef struct {logic [3:0] g; logic c;} exp_t;
  typedef struct {logic [3:0] m, a, b; int g; logic c;} vec_t;
  exp_t q[$];
  exp_t e;
  vec_t tv[10];
  int gi[5], gt[5];
  int k, n;
  logic stable;
`ifdef GATE_RR_ARBITER_CHECK_EN
  logic err, err1;
`endif

  gate_rr_arbiter #(.NUM_REQ(4), .GATE_LATENCY(1)) u0 (
    .clk(clk), .reset(reset), .req_valid(rv), .req_a(ra), .req_b(rb), .req_ready(rq),
    .resp_valid(pv), .resp_c(pc), .resp_ready(pr), .gate_a(ga), .gate_b(gb),
    .gate_c(gc), .gate_ready(grdy)
`ifdef GATE_RR_ARBITER_CHECK_EN
    , .err(err)
`endif
  );

  gate_rr_arbiter #(.NUM_REQ(4), .GATE_LATENCY(3)) u1 (
    .clk(clk), .reset(reset), .req_valid(rv1), .req_a(ra1), .req_b(rb1), .req_ready(rq1),
    .resp_valid(pv1), .resp_c(pc1), .resp_ready(pr1), .gate_a(ga1), .gate_b(gb1),
    .gate_c(gc1), .gate_ready(grdy1)
`ifdef GATE_RR_ARBITER_CHECK_EN
    , .err(err1)
`endif
  );

  assign gc = gmode ? (ga & gb) : (ga ^ gb);
  assign gc1 = ga1 ^ gb1;

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic int idx_of(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic gate_model(input logic a, input logic b);
    return gmode ? (a & b) : (a ^ b);
  endfunction

  // scoreboard: push on request handshake, pop and compare on response handshake
  always @(negedge clk) begin
    #1;
    if (reset) q.delete();
    else begin
      if (|(rq & rv)) q.push_back('{rq, gate_model(|(ra & rq), |(rb & rq))});
      if (|(pv & pr)) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_empty: response %0d with nothing expected", pv);
        end else begin
          e = q.pop_front();
          chk("sb_grant", 32'(pv), 32'(e.g));
          chk("sb_c", 32'(pc), 32'(e.c));
        end
      end
    end
  end

  task automatic txn(input logic [3:0] m, input logic [3:0] a, input logic [3:0] b, input int g, input logic c);
    int w;
    @(negedge clk);
    rv = m; ra = a; rb = b; pr = 4'hF;
    #1;
    w = 0;
    while (rq == 0 && w < 10) begin @(negedge clk); #1; w++; end
    chk("grant", 32'(rq), 32'(4'b1 << g));
    @(negedge clk);
    rv = 0;
    #1;
    w = 0;
    while (pv == 0 && w < 20) begin @(negedge clk); #1; w++; end
    chk("latency", w, 1);
    chk("resp_c", 32'(pc), 32'(c));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; rv = 0; pr = 0;
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    tv[0] = '{4'b0001, 4'b0001, 4'b0000, 0, 1'b1};
    tv[1] = '{4'b0011, 4'b0000, 4'b0000, 1, 1'b0};
    tv[2] = '{4'b0100, 4'b0000, 4'b0000, 2, 1'b0};
    tv[3] = '{4'b0100, 4'b0000, 4'b0100, 2, 1'b1};
    tv[4] = '{4'b0100, 4'b0100, 4'b0100, 2, 1'b0};
    tv[5] = '{4'b0100, 4'b0100, 4'b0000, 2, 1'b1};
    tv[6] = '{4'b1111, 4'b1000, 4'b0000, 3, 1'b1};
    tv[7] = '{4'b1010, 4'b0010, 4'b0010, 1, 1'b0};
    tv[8] = '{4'b1001, 4'b0000, 4'b1000, 3, 1'b1};
    tv[9] = '{4'b0110, 4'b0010, 4'b0000, 1, 1'b1};
    reset = 1; gmode = 0; grdy = 1; grdy1 = 1;
    rv = 4'hF; ra = 4'hF; rb = 0; pr = 0;
    rv1 = 0; ra1 = 0; rb1 = 0; pr1 = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_ready", 32'(rq), 0);
    chk("rst_resp_valid", 32'(pv), 0);
    chk("rst_resp_c", 32'(pc), 0);
    chk("rst_gate_a", 32'(ga), 0);
    chk("rst_gate_b", 32'(gb), 0);
    @(negedge clk);
    reset = 0; rv = 0;
    for (int i = 0; i < 10; i++) txn(tv[i].m, tv[i].a, tv[i].b, tv[i].g, tv[i].c);
    // gate not ready in IDLE: request offered then withdrawn, nothing granted
    @(negedge clk);
    grdy = 0; rv = 4'b0001;
    #1;
    chk("idle_not_ready", 32'(rq), 0);
    @(negedge clk);
    grdy = 1; rv = 0;
    #1;
    chk("no_resp_after_drop", 32'(pv), 0);
    txn(4'b0011, 4'b0001, 4'b0001, 0, 1'b0);
    // response back-pressure: outputs stable, non-granted resp_ready ignored, no new accept
    @(negedge clk);
    rv = 4'b0010; ra = 4'b0010; rb = 0; pr = 0;
    #1;
    chk("bp_grant", 32'(rq), 32'(4'b0010));
    @(negedge clk);
    rv = 4'hF;
    #1;
    n = 0;
    while (pv == 0 && n < 20) begin @(negedge clk); #1; n++; end
    stable = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      pr = 4'b1101;
      #1;
      if (pv !== 4'b0010 || pc !== 1'b1 || rq !== 4'b0000) stable = 0;
    end
    chk("bp_stable", 32'(stable), 1);
    @(negedge clk);
    pr = 4'b0010; rv = 0;
    @(negedge clk);
    pr = 0;
    #1;
    chk("bp_released", 32'(pv), 0);
    // continuous requests from all four with fresh operands
    do_reset();
    k = 0;
    for (int cyc = 0; cyc < 40 && k < 5; cyc++) begin
      @(negedge clk);
      ra = 4'($urandom); rb = 4'($urandom); rv = 4'hF; pr = 4'hF;
      #1;
      if (rq != 0) begin gi[k] = idx_of(rq); gt[k] = cyc; k++; end
    end
    @(negedge clk);
    rv = 0;
    repeat (4) @(negedge clk);
    chk("tp_count", k, 5);
    for (int i = 0; i < 5; i++) chk("tp_order", gi[i], i % 4);
    for (int i = 0; i < 4; i++) chk("tp_gap", gt[i+1] - gt[i], 3);
    // reset in EXEC abandons the transaction and returns the pointer to 0
    @(negedge clk);
    rv = 4'b0100; ra = 4'b0100; rb = 0; pr = 4'hF;
    #1;
    chk("abort_grant", 32'(rq), 32'(4'b0100));
    @(negedge clk);
    rv = 0; reset = 1;
    @(negedge clk);
    reset = 0;
    #1;
    chk("abort_resp_valid", 32'(pv), 0);
    chk("abort_gate_a", 32'(ga), 0);
    chk("abort_gate_b", 32'(gb), 0);
    chk("abort_resp_c", 32'(pc), 0);
    repeat (3) @(negedge clk);
    #1;
    chk("abort_no_resp", 32'(pv), 0);
    txn(4'b1001, 4'b0001, 4'b0000, 0, 1'b1);
    // gate stall during EXEC on the three-cycle-latency instance
    @(negedge clk);
    rv1 = 4'b0001; ra1 = 4'b0001; rb1 = 0; pr1 = 0; grdy1 = 1;
    #1;
    chk("stall_grant", 32'(rq1), 32'(4'b0001));
    n = 0;
    stable = 1;
    while (pv1 == 0 && n < 30) begin
      @(negedge clk);
      n++;
      rv1 = 0;
      grdy1 = (n < 2 || n > 6);
      #1;
      if (ga1 !== 1'b1 || gb1 !== 1'b0) stable = 0;
    end
    chk("stall_latency", n, 9);
    chk("stall_operands", 32'(stable), 1);
    chk("stall_resp_valid", 32'(pv1), 32'(4'b0001));
    chk("stall_resp_c", 32'(pc1), 1);
    @(negedge clk);
    pr1 = 4'b0001;
    @(negedge clk);
    pr1 = 0;
    #1;
    chk("stall_done", 32'(pv1), 0);
    chk("operand_hold", 32'(ga1), 1);
`ifdef GATE_RR_ARBITER_CHECK_EN
    chk("err_clear", 32'(err), 0);
    gmode = 1;
    txn(4'b0001, 4'b0001, 4'b0001, 0, 1'b1);
    #1;
    chk("err_set", 32'(err), 1);
    gmode = 0;
    txn(4'b0001, 4'b0001, 4'b0000, 0, 1'b1);
    #1;
    chk("err_sticky", 32'(err), 1);
`endif
    @(negedge clk);
    #2;
    chk("sb_left", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
